dcache_ctrl_fsm: RTL and testbench
==================================

Name: dcache_ctrl_fsm

Overview:
Miss-handling controller for the 2-way, 16-set, 256-bit-line data cache SRAM. It sits between the CPU load/store port, the cache SRAM and the word-addressed-by-line main memory. It decodes CPU addresses, serves hits, and merges store words into lines. On a miss it sequences dirty-victim write-back and line refill, and stalls the CPU until the access can complete as a hit.

Parameters:
- ADDR_W, 32, CPU/memory byte-address width
- WORD_W, 32, CPU data word width
- LINE_W, 256, cache line width (32 bytes)
- SET_W, 4, set index width (16 sets)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- cpu_req_i  in  1  CPU access request (load or store)
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address; tag [31:9], index [8:5], offset [4:0]
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data, word selected by cpu_addr_i[4:2]
- cpu_stall_o  out  1  CPU must hold request and inputs while high
- sram_addr_o  out  4  set index to SRAM
- sram_tag_o  out  25  {valid, dirty, tag[22:0]} write tag
- sram_data_o  out  256  line write data
- sram_enable_o  out  1  SRAM access enable
- sram_write_o  out  1  SRAM write strobe, committed at next clk_i edge
- sram_tag_i  in  25  hit way tag, or LRU victim tag on miss
- sram_data_i  in  256  hit way line, or LRU victim line on miss
- sram_hit_i  in  1  combinational hit from SRAM
- mem_enable_o  out  1  memory request, level, held until ack
- mem_write_o  out  1  1 = write-back, 0 = refill read
- mem_addr_o  out  32  line-aligned address, [4:0] = 0
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  refill line
- mem_ack_i  in  1  single-cycle completion from memory

Behaviour:
- States: IDLE, MISS, WRITEBACK, REFILL, REFILL_DONE. Encoded as 3 bits; reset state is IDLE.
- Reset values: all outputs 0, LRU untouched. Reset mid-transaction returns to IDLE and abandons the memory request (mem_enable_o drops).
- IDLE with cpu_req_i=0: sram_enable_o=0, cpu_stall_o=0.
- IDLE with cpu_req_i=1: sram_enable_o=1, sram_addr_o=index.
- Load hit: cpu_data_o = sram_data_i word[offset[4:2]] in the same cycle, stall=0. Zero-cycle latency.
- Store hit: sram_write_o=1, sram_tag_o={1,1,tag}. sram_data_o is sram_data_i with word[offset[4:2]] replaced by cpu_data_i. stall=0.
- Miss (cpu_req_i & !sram_hit_i): stall=1 that cycle; go to MISS. Index, tag and victim tag are latched.
- MISS, one cycle: if victim tag[24] & tag[23] (valid and dirty), go to WRITEBACK; else go to REFILL.
- WRITEBACK:
  - mem_enable_o=1, mem_write_o=1.
  - mem_addr_o = {victim tag[22:0], index, 5'b0}.
  - mem_data_o = latched victim line.
  - On mem_ack_i, go to REFILL.
- REFILL:
  - mem_enable_o=1, mem_write_o=0.
  - mem_addr_o = {cpu tag, index, 5'b0}.
  - On mem_ack_i: sram_write_o=1, sram_tag_o={1,0,tag}, sram_data_o=mem_data_i. Go to REFILL_DONE.
- REFILL_DONE: one idle cycle with stall=1, then IDLE. The access now hits; a store then completes as a store hit.
- cpu_stall_o=1 in every non-IDLE state.
- mem_ack_i outside WRITEBACK/REFILL is ignored.
- cpu_req_i dropping mid-miss is illegal. The controller still completes the refill from latched values.
- Only one outstanding miss exists; no hit-under-miss.

Optional Feature:
- Macro DCACHE_CTRL_STATS_EN.
- Defined: adds outputs stat_hit_o, stat_miss_o, stat_wb_o (32 bits each, saturating at 0xFFFFFFFF, cleared by rst_i).
  - stat_hit_o increments per IDLE hit cycle.
  - stat_miss_o increments per IDLE→MISS transition.
  - stat_wb_o increments per WRITEBACK ack.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package dcache_pkg:
  - state enum.
  - Field constants TAG_W=23, IDX_W=4, OFF_W=5, VALID_BIT=24, DIRTY_BIT=23.
  - LINE_W, WORD_W.
- One sub-module: dcache_word_merge. Purely combinational; performs word select for loads and word replace for stores.

Test Plan:
- Load to cold address 0x0000_0120:
  - stall 1 through MISS→REFILL; mem read at 0x0000_0120.
  - Refill line word[0]=0xDEADBEEF.
  - After REFILL_DONE, cpu_data_o=0xDEADBEEF, stall 0; total 4+memory-latency cycles.
- Store hit 0x0000_0124 data 0x12345678: same-cycle sram_write_o=1, sram_tag_o[24:23]=2'b11, word[1] replaced, other words unchanged.
- Fill both ways of set 9 dirty, then miss a third tag in set 9:
  - WRITEBACK to the LRU victim address with the dirty line.
  - Then REFILL; refilled tag dirty=0.
- Miss on set with clean victim: no mem_write_o pulse, direct MISS→REFILL.
- Assert rst_i during REFILL: all outputs 0 asynchronously; state IDLE; next request restarts cleanly.
- With DCACHE_CTRL_STATS_EN: 3 hits, 2 misses, 1 write-back → counters read 3/2/1.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared state type and address field constants for the data cache controller
package dcache_pkg;
   localparam int TAG_W     = 23;
   localparam int IDX_W     = 4;
   localparam int OFF_W     = 5;
   localparam int VALID_BIT = 24;
   localparam int DIRTY_BIT = 23;
   localparam int LINE_W    = 256;
   localparam int WORD_W    = 32;
   localparam int SEL_W     = 3;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      MISS        = 3'd1,
      WRITEBACK   = 3'd2,
      REFILL      = 3'd3,
      REFILL_DONE = 3'd4
   } state_t;
endpackage

// File: rtl/dcache_word_merge.sv
// rtl/dcache_word_merge.sv - word select for loads and word replace for stores within a cache line
module dcache_word_merge
   import dcache_pkg::*;
(
   input  logic [LINE_W-1:0] line,
   input  logic [SEL_W-1:0]  sel,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata,
   output logic [LINE_W-1:0] merged
);
   assign rdata = line[sel*WORD_W +: WORD_W];

   always_comb begin
      merged = line;
      merged[sel*WORD_W +: WORD_W] = wdata;
   end
endmodule

// File: rtl/dcache_ctrl_fsm.sv
// rtl/dcache_ctrl_fsm.sv - miss-handling controller for the 2-way data cache; DCACHE_CTRL_STATS_EN adds hit/miss/write-back counters
module dcache_ctrl_fsm
   import dcache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int SET_W  = IDX_W
)
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_req_i,
   input  logic                 cpu_we_i,
   input  logic [ADDR_W-1:0]    cpu_addr_i,
   input  logic [WORD_W-1:0]    cpu_data_i,
   output logic [WORD_W-1:0]    cpu_data_o,
   output logic                 cpu_stall_o,
   output logic [SET_W-1:0]     sram_addr_o,
   output logic [TAG_W+1:0]     sram_tag_o,
   output logic [LINE_W-1:0]    sram_data_o,
   output logic                 sram_enable_o,
   output logic                 sram_write_o,
   input  logic [TAG_W+1:0]     sram_tag_i,
   input  logic [LINE_W-1:0]    sram_data_i,
   input  logic                 sram_hit_i,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [ADDR_W-1:0]    mem_addr_o,
   output logic [LINE_W-1:0]    mem_data_o,
   input  logic [LINE_W-1:0]    mem_data_i,
   input  logic                 mem_ack_i
`ifdef DCACHE_CTRL_STATS_EN
   ,
   output logic [31:0]          stat_hit_o,
   output logic [31:0]          stat_miss_o,
   output logic [31:0]          stat_wb_o
`endif
);
   state_t             state, state_nxt;
   logic [SET_W-1:0]   idx_q;
   logic [TAG_W-1:0]   tag_q;
   logic [TAG_W+1:0]   vtag_q;
   logic [LINE_W-1:0]  vline_q;

   logic [TAG_W-1:0]   cpu_tag;
   logic [SET_W-1:0]   cpu_idx;
   logic [SEL_W-1:0]   cpu_sel;
   logic [WORD_W-1:0]  word_rd;
   logic [LINE_W-1:0]  line_merged;
   logic               idle_hit, idle_miss;
   logic               unused_addr_bits;

   assign cpu_tag          = cpu_addr_i[ADDR_W-1 -: TAG_W];
   assign cpu_idx          = cpu_addr_i[OFF_W +: SET_W];
   assign cpu_sel          = cpu_addr_i[OFF_W-1:2];
   assign unused_addr_bits = ^cpu_addr_i[1:0];
   assign idle_hit         = (state == IDLE) && cpu_req_i && sram_hit_i;
   assign idle_miss        = (state == IDLE) && cpu_req_i && !sram_hit_i;

   dcache_word_merge u_merge (
      .line   (sram_data_i),
      .sel    (cpu_sel),
      .wdata  (cpu_data_i),
      .rdata  (word_rd),
      .merged (line_merged)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   // The SRAM presents the LRU victim on a miss, so capture it before the refill overwrites that way.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q   <= '0;
         tag_q   <= '0;
         vtag_q  <= '0;
         vline_q <= '0;
      end else if (idle_miss) begin
         idx_q   <= cpu_idx;
         tag_q   <= cpu_tag;
         vtag_q  <= sram_tag_i;
         vline_q <= sram_data_i;
      end
   end

   always_comb begin
      state_nxt     = state;
      cpu_data_o    = '0;
      cpu_stall_o   = 1'b0;
      sram_addr_o   = '0;
      sram_tag_o    = '0;
      sram_data_o   = '0;
      sram_enable_o = 1'b0;
      sram_write_o  = 1'b0;
      mem_enable_o  = 1'b0;
      mem_write_o   = 1'b0;
      mem_addr_o    = '0;
      mem_data_o    = '0;
      unique case (state)
         IDLE: begin
            if (cpu_req_i) begin
               sram_enable_o = 1'b1;
               sram_addr_o   = cpu_idx;
               if (sram_hit_i) begin
                  if (cpu_we_i) begin
                     sram_write_o = 1'b1;
                     sram_tag_o   = {2'b11, cpu_tag};
                     sram_data_o  = line_merged;
                  end else begin
                     cpu_data_o = word_rd;
                  end
               end else begin
                  cpu_stall_o = 1'b1;
                  state_nxt   = MISS;
               end
            end
         end
         MISS: begin
            cpu_stall_o = 1'b1;
            state_nxt   = (vtag_q[VALID_BIT] && vtag_q[DIRTY_BIT]) ? WRITEBACK : REFILL;
         end
         WRITEBACK: begin
            cpu_stall_o  = 1'b1;
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {vtag_q[TAG_W-1:0], idx_q, {OFF_W{1'b0}}};
            mem_data_o   = vline_q;
            if (mem_ack_i) state_nxt = REFILL;
         end
         REFILL: begin
            cpu_stall_o  = 1'b1;
            mem_enable_o = 1'b1;
            mem_addr_o   = {tag_q, idx_q, {OFF_W{1'b0}}};
            sram_addr_o  = idx_q;
            if (mem_ack_i) begin
               sram_enable_o = 1'b1;
               sram_write_o  = 1'b1;
               sram_tag_o    = {2'b10, tag_q};
               sram_data_o   = mem_data_i;
               state_nxt     = REFILL_DONE;
            end
         end
         REFILL_DONE: begin
            cpu_stall_o = 1'b1;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Reset forces every output low even though IDLE itself would echo a pending request.
      if (rst_i) begin
         cpu_data_o    = '0;
         cpu_stall_o   = 1'b0;
         sram_addr_o   = '0;
         sram_tag_o    = '0;
         sram_data_o   = '0;
         sram_enable_o = 1'b0;
         sram_write_o  = 1'b0;
         mem_enable_o  = 1'b0;
         mem_write_o   = 1'b0;
         mem_addr_o    = '0;
         mem_data_o    = '0;
      end
   end

`ifdef DCACHE_CTRL_STATS_EN
   logic [31:0] hit_cnt, miss_cnt, wb_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
         wb_cnt   <= '0;
      end else begin
         if (idle_hit && hit_cnt != 32'hFFFF_FFFF)   hit_cnt  <= hit_cnt + 32'd1;
         if (idle_miss && miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
         if (state == WRITEBACK && mem_ack_i && wb_cnt != 32'hFFFF_FFFF) wb_cnt <= wb_cnt + 32'd1;
      end
   end

   assign stat_hit_o  = hit_cnt;
   assign stat_miss_o = miss_cnt;
   assign stat_wb_o   = wb_cnt;
`endif
endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// tb/tb_dcache_ctrl_fsm.sv - bench for dcache_ctrl_fsm with SRAM/memory models and a set-associative reference cache
module tb_dcache_ctrl_fsm;
   logic          clk_i, rst_i;
   logic          cpu_req_i, cpu_we_i;
   logic [31:0]   cpu_addr_i, cpu_data_i, cpu_data_o;
   logic          cpu_stall_o;
   logic [3:0]    sram_addr_o;
   logic [24:0]   sram_tag_o, sram_tag_i;
   logic [255:0]  sram_data_o, sram_data_i;
   logic          sram_enable_o, sram_write_o, sram_hit_i;
   logic          mem_enable_o, mem_write_o, mem_ack_i;
   logic [31:0]   mem_addr_o;
   logic [255:0]  mem_data_o, mem_data_i;
`ifdef DCACHE_CTRL_STATS_EN
   logic [31:0]   stat_hit_o, stat_miss_o, stat_wb_o;
`endif

   dcache_ctrl_fsm dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
      .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
      .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
      .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
      .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_CTRL_STATS_EN
      , .stat_hit_o(stat_hit_o), .stat_miss_o(stat_miss_o), .stat_wb_o(stat_wb_o)
`endif
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Backing memory contents: a fixed pattern until a line is written back.
   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a == 32'h120) ? 32'hDEAD_BEEF : ((a * 32'h9E37_79B1) ^ 32'h0F0F_0F0F);
   endfunction

   logic [255:0] phys [logic [31:0]];
   logic [31:0]  gold [logic [31:0]];

   function automatic logic [255:0] phys_line(input logic [31:0] la);
      logic [255:0] l;
      if (phys.exists(la)) return phys[la];
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la + 32'(i*4));
      return l;
   endfunction

   function automatic logic [31:0] gold_word(input logic [31:0] a);
      return gold.exists(a) ? gold[a] : init_word(a);
   endfunction

   function automatic logic [255:0] gold_line(input logic [31:0] la);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = gold_word(la + 32'(i*4));
      return l;
   endfunction

   // Two-way SRAM with per-set LRU; lookup is driven by the CPU address.
   logic [24:0]  tag_arr [2][16];
   logic [255:0] dat_arr [2][16];
   logic         lru [16];
   logic         hit0, hit1, wr_way;
   logic [3:0]   rd_idx;

   initial begin
      for (int w = 0; w < 2; w++)
         for (int s = 0; s < 16; s++) begin
            tag_arr[w][s] = '0;
            dat_arr[w][s] = '0;
         end
      for (int s = 0; s < 16; s++) lru[s] = 1'b0;
   end

   always_comb begin
      rd_idx      = cpu_addr_i[8:5];
      hit0        = tag_arr[0][rd_idx][24] && (tag_arr[0][rd_idx][22:0] == cpu_addr_i[31:9]);
      hit1        = tag_arr[1][rd_idx][24] && (tag_arr[1][rd_idx][22:0] == cpu_addr_i[31:9]);
      wr_way      = (hit0 || hit1) ? (hit1 && !hit0) : lru[rd_idx];
      sram_hit_i  = hit0 || hit1;
      sram_tag_i  = tag_arr[wr_way][rd_idx];
      sram_data_i = dat_arr[wr_way][rd_idx];
   end

   always @(posedge clk_i) begin
      if (sram_enable_o && sram_write_o) begin
         tag_arr[wr_way][sram_addr_o] <= sram_tag_o;
         dat_arr[wr_way][sram_addr_o] <= sram_data_o;
         lru[sram_addr_o]             <= ~wr_way;
      end else if (sram_enable_o && sram_hit_i) begin
         lru[sram_addr_o] <= ~wr_way;
      end
   end

   // Memory responder: random latency, single-cycle ack, logs each completed transfer.
   typedef struct packed {
      logic         we;
      logic [31:0]  addr;
      logic [255:0] wdata;
      logic [255:0] rdata;
      logic [31:0]  lat;
      logic         sw;
      logic [24:0]  stag;
      logic [255:0] sdata;
   } tx_t;

   tx_t txq [$];
   int  lat_override = -1;

   initial begin
      int  cnt;
      int  lat_used;
      bit  active;
      tx_t t;
      mem_ack_i  = 1'b0;
      mem_data_i = '0;
      active     = 1'b0;
      cnt        = 0;
      lat_used   = 0;
      forever begin
         @(negedge clk_i);
         mem_ack_i = 1'b0;
         if (!mem_enable_o) begin
            active = 1'b0;
            continue;
         end
         if (!active) begin
            active   = 1'b1;
            cnt      = (lat_override >= 0) ? lat_override : int'($urandom_range(0, 3));
            lat_used = cnt;
         end
         if (cnt == 0) begin
            t       = '0;
            t.we    = mem_write_o;
            t.addr  = mem_addr_o;
            t.wdata = mem_data_o;
            t.lat   = 32'(lat_used);
            if (mem_write_o) phys[mem_addr_o] = mem_data_o;
            else             mem_data_i = phys_line(mem_addr_o);
            t.rdata   = mem_data_i;
            mem_ack_i = 1'b1;
            active    = 1'b0;
            #1;
            t.sw    = sram_write_o;
            t.stag  = sram_tag_o;
            t.sdata = sram_data_o;
            txq.push_back(t);
         end else begin
            cnt--;
         end
      end
   end

   // Reference cache: per set, resident tags ordered LRU first.
   typedef struct packed {
      logic [22:0] tag;
      logic        dirty;
   } entry_t;

   entry_t mset [16][$];
   int exp_hits = 0, exp_misses = 0, exp_wbs = 0;

   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data);
      logic [3:0]   set;
      logic [22:0]  tag;
      logic [31:0]  la, wb_addr;
      logic [255:0] wb_line, exp_line;
      int           pos, n0, k, cyc, exp_cyc, ntx;
      bit           exp_hit, exp_wb;
      tx_t          t;
      entry_t       e;
      set = addr[8:5];
      tag = addr[31:9];
      la  = {addr[31:5], 5'b0};
      pos = -1;
      foreach (mset[set][i]) if (mset[set][i].tag == tag) pos = i;
      exp_hit = (pos >= 0);
      exp_wb  = !exp_hit && (mset[set].size() == 2) && mset[set][0].dirty;
      wb_addr = '0;
      wb_line = '0;
      if (exp_wb) begin
         wb_addr = {mset[set][0].tag, set, 5'b0};
         wb_line = gold_line(wb_addr);
      end
      n0 = txq.size();

      cpu_req_i  = 1'b1;
      cpu_we_i   = we;
      cpu_addr_i = addr;
      cpu_data_i = data;
      #1;
      cyc = 0;
      while (cpu_stall_o && cyc < 200) begin
         @(negedge clk_i);
         #1;
         cyc++;
      end
      chk("stall_released", cpu_stall_o, 1'b0);
      ntx = txq.size() - n0;
      if (exp_hit) begin
         chk("hit_zero_stall", cyc, 0);
         chk("hit_no_mem", ntx, 0);
      end else begin
         chk("miss_mem_tx_count", ntx, exp_wb ? 2 : 1);
         if (ntx == (exp_wb ? 2 : 1)) begin
            k       = n0;
            exp_cyc = 4;
            if (exp_wb) begin
               t = txq[k];
               k++;
               chk("wb_is_write", t.we, 1'b1);
               chk("wb_addr", t.addr, wb_addr);
               chk("wb_line", t.wdata, wb_line);
               exp_cyc += int'(t.lat) + 1;
            end
            t = txq[k];
            chk("refill_is_read", t.we, 1'b0);
            chk("refill_addr", t.addr, la);
            chk("refill_coherent", t.rdata, gold_line(la));
            chk("refill_sram_write", t.sw, 1'b1);
            chk("refill_tag_clean", t.stag, {2'b10, tag});
            chk("refill_sram_data", t.sdata, t.rdata);
            exp_cyc += int'(t.lat);
            chk("miss_stall_cycles", cyc, exp_cyc);
         end
      end
      chk("sram_enable", sram_enable_o, 1'b1);
      chk("sram_addr", sram_addr_o, set);
      if (we) begin
         exp_line = gold_line(la);
         exp_line[addr[4:2]*32 +: 32] = data;
         chk("store_sram_write", sram_write_o, 1'b1);
         chk("store_tag_dirty", sram_tag_o, {2'b11, tag});
         chk("store_merged_line", sram_data_o, exp_line);
      end else begin
         chk("load_no_write", sram_write_o, 1'b0);
         chk("load_data", cpu_data_o, gold_word({addr[31:2], 2'b00}));
      end

      exp_hits++;
      if (exp_hit) begin
         e = mset[set][pos];
         mset[set].delete(pos);
         if (we) e.dirty = 1'b1;
         mset[set].push_back(e);
      end else begin
         exp_misses++;
         if (exp_wb) exp_wbs++;
         if (mset[set].size() == 2) void'(mset[set].pop_front());
         e.tag   = tag;
         e.dirty = we;
         mset[set].push_back(e);
      end
      if (we) gold[{addr[31:2], 2'b00}] = data;

      @(negedge clk_i);
      cpu_req_i = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1);
   end

   initial begin
      logic [3:0]  rs;
      logic [22:0] rt;
      int          cyc;
      rst_i      = 1'b1;
      cpu_req_i  = 1'b1;
      cpu_we_i   = 1'b1;
      cpu_addr_i = 32'h0000_0124;
      cpu_data_i = 32'h5555_5555;
      #2;
      chk("reset_outputs", {cpu_data_o, cpu_stall_o, sram_addr_o, sram_tag_o, sram_enable_o,
                            sram_write_o, mem_enable_o, mem_write_o, mem_addr_o}, '0);
      chk("reset_sram_data", sram_data_o, '0);
      chk("reset_mem_data", mem_data_o, '0);
      cpu_req_i = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      #1;
      chk("idle_no_stall", cpu_stall_o, 1'b0);
      chk("idle_no_sram", sram_enable_o, 1'b0);
      @(negedge clk_i);

      access(1'b0, 32'h0000_0120, 32'h0);
      chk("cold_load_deadbeef", gold_word(32'h120), 32'hDEAD_BEEF);
      access(1'b1, 32'h0000_0124, 32'h1234_5678);
      access(1'b0, 32'h0000_0124, 32'h0);
      access(1'b1, 32'h0000_0328, 32'hA1A1_A1A1);
      access(1'b0, 32'h0000_0520, 32'h0);
      access(1'b0, 32'h0000_0060, 32'h0);
      access(1'b0, 32'h0000_0260, 32'h0);
      access(1'b0, 32'h0000_0460, 32'h0);

      lat_override = 30;
      cpu_req_i    = 1'b1;
      cpu_we_i     = 1'b0;
      cpu_addr_i   = 32'h0000_41E0;
      cyc = 0;
      while (!(mem_enable_o && !mem_write_o) && cyc < 20) begin
         @(negedge clk_i);
         cyc++;
      end
      chk("rst_test_in_refill", mem_enable_o, 1'b1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("rst_async_outputs", {cpu_data_o, cpu_stall_o, sram_addr_o, sram_tag_o, sram_enable_o,
                                sram_write_o, mem_enable_o, mem_write_o, mem_addr_o}, '0);
      @(negedge clk_i);
      cpu_req_i = 1'b0;
      @(negedge clk_i);
      rst_i        = 1'b0;
      lat_override = -1;
      exp_hits     = 0;
      exp_misses   = 0;
      exp_wbs      = 0;
      @(negedge clk_i);
      #1;
      chk("rst_back_idle", {cpu_stall_o, mem_enable_o, sram_enable_o}, 3'b000);
      @(negedge clk_i);
      access(1'b0, 32'h0000_41E0, 32'h0);

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 3))
            0: rs = 4'd0;
            1: rs = 4'd1;
            2: rs = 4'd2;
            default: rs = 4'd9;
         endcase
         rt = 23'($urandom_range(0, 3));
         access(1'($urandom_range(0, 1)), {rt, rs, 3'($urandom_range(0, 7)), 2'b00}, $urandom);
      end

`ifdef DCACHE_CTRL_STATS_EN
      chk("stat_hit", stat_hit_o, exp_hits);
      chk("stat_miss", stat_miss_o, exp_misses);
      chk("stat_wb", stat_wb_o, exp_wbs);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
